fila_de_instrucoes: RTL and testbench
=====================================

FILA_DE_INSTRUCOES -- requirements
Module: fila_de_instrucoes

Interface
REQ-001 The block SHALL use a single clock and an asynchronous, active-low reset.
REQ-002 Clock  input  1  rising-edge clock for all state.
REQ-003 Reset  input  1  asynchronous, active-low reset; 0 = reset asserted.
REQ-004 Pop  input  1  dispatch request; dequeues the head instruction on a rising edge when Empty=0.
REQ-005 Instrucao_Despachada  output  16  last dispatched instruction, registered.
REQ-006 Full  output  1  high when the queue holds DEPTH entries.
REQ-007 Empty  output  1  high when the queue holds 0 entries.
REQ-008 Parameters SHALL be WIDTH (default 16, instruction width), DEPTH (default 8, queue entries) and PROG_LEN (default 16, program words).

Function
REQ-009 The block SHALL contain a read-only program of PROG_LEN words, PROGRAM[i] = 16'hA000 | i for i = 0..15.
REQ-010 The block SHALL contain a circular FIFO of DEPTH x WIDTH entries, with head pointer, tail pointer, occupancy count (0..DEPTH) and fetch PC (0..PROG_LEN).
REQ-011 Fetch: on each rising edge where count < DEPTH and PC < PROG_LEN (pre-edge values), the block SHALL write PROGRAM[PC] at the tail, advance the tail modulo DEPTH, and increment PC.
REQ-012 Once PC = PROG_LEN, fetching SHALL stop permanently until reset; the program does not wrap.
REQ-013 Dispatch: on a rising edge with Pop=1 and count > 0, the block SHALL load Instrucao_Despachada with the head entry and advance the head modulo DEPTH.
REQ-014 Pop=1 while Empty=1 SHALL be ignored: no pointer change, and Instrucao_Despachada holds its value.
REQ-015 With Pop=0, Instrucao_Despachada SHALL hold its value.
REQ-016 When a fetch and a dispatch occur on the same edge, count SHALL remain unchanged, and both the head and tail pointers SHALL advance.
REQ-017 When Full=1 on a dispatch edge, no fetch SHALL occur on that edge. Refill SHALL occur on the following edge.
REQ-018 Full SHALL equal (count == DEPTH) and Empty SHALL equal (count == 0), both decoded combinationally from registered state.
REQ-019 Dispatch latency SHALL be one edge from Pop sampled high to the new value on Instrucao_Despachada.
REQ-020 Entries SHALL be dispatched strictly in program order, with no loss or duplication across pointer wrap-around.

Reset
REQ-021 While Reset=0, the block SHALL immediately force: head=0, tail=0, count=0, PC=0, Instrucao_Despachada=16'h0000, Empty=1, Full=0.
REQ-022 Reset asserted mid-operation SHALL discard all queued entries and restart fetching from PROGRAM[0] after release.
REQ-023 The first fetch SHALL occur on the first rising edge at which Reset=1.
REQ-024 FIFO storage contents need not be reset.

Structure
REQ-025 The shared package fila_pkg SHALL hold WIDTH, DEPTH, PROG_LEN, the pointer and count widths, and the PROGRAM constant array.
REQ-026 The program store SHALL be a separate sub-module, memoria_de_programa: combinational read, 4-bit address, 16-bit data. The FIFO and control logic SHALL reside in fila_de_instrucoes.

Verification
REQ-027 Reset=0 with any Pop value -> Empty=1, Full=0, Instrucao_Despachada=16'h0000.
REQ-028 Release reset with Pop=0 -> Empty=0 after edge 1, Full=1 after edge 8, PC=8, then stable with no further change.
REQ-029 From Full, hold Pop=1 -> Instrucao_Despachada = A000, A001, ..., A00F on 16 consecutive edges, Empty=1 after the A00F edge, then output held at A00F.
REQ-030 From Full, apply a one-cycle Pop pulse -> output A000, Full=0 for exactly one cycle, Full=1 again after the next edge.
REQ-031 Pop=1 while Empty (first edge after reset release) -> output stays 16'h0000; the first dispatch returns A000.
REQ-032 Assert Reset asynchronously between edges while partially drained -> outputs return to reset values at once; after release the sequence restarts at A000.

Source files
------------

// File: rtl/fila_pkg.sv
// Shared sizing constants and the fixed instruction program for the instruction queue.
package fila_pkg;

  localparam int unsigned WIDTH    = 16;
  localparam int unsigned DEPTH    = 8;
  localparam int unsigned PROG_LEN = 16;
  localparam int unsigned PTR_W    = 3;
  localparam int unsigned CNT_W    = 4;
  localparam int unsigned PC_W     = 5;
  localparam int unsigned ADDR_W   = 4;

  localparam logic [WIDTH-1:0] PROGRAM [PROG_LEN] = '{
    16'hA000, 16'hA001, 16'hA002, 16'hA003,
    16'hA004, 16'hA005, 16'hA006, 16'hA007,
    16'hA008, 16'hA009, 16'hA00A, 16'hA00B,
    16'hA00C, 16'hA00D, 16'hA00E, 16'hA00F
  };

endpackage

// File: rtl/memoria_de_programa.sv
// Read-only program store with a combinational read port.
module memoria_de_programa
  import fila_pkg::*;
(
  input  logic [ADDR_W-1:0] addr_i,
  output logic [WIDTH-1:0]  dado_c
);

  assign dado_c = PROGRAM[addr_i];

endmodule

// File: rtl/fila_de_instrucoes.sv
// Circular instruction queue that prefetches the fixed program and dispatches one
// instruction per Pop, oldest first.
module fila_de_instrucoes #(
  parameter int unsigned WIDTH    = fila_pkg::WIDTH,
  parameter int unsigned DEPTH    = fila_pkg::DEPTH,
  parameter int unsigned PROG_LEN = fila_pkg::PROG_LEN
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             Pop,
  output logic [WIDTH-1:0] Instrucao_Despachada,
  output logic             Full,
  output logic             Empty
);

  import fila_pkg::*;

  logic [PTR_W-1:0]  head_q, head_d;
  logic [PTR_W-1:0]  tail_q, tail_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [PC_W-1:0]   pc_q, pc_d;
  logic [WIDTH-1:0]  out_q, out_d;
  logic [WIDTH-1:0]  mem_q [DEPTH];
  logic [fila_pkg::WIDTH-1:0] prog_word_c;
  logic              fetch_c;
  logic              pop_c;

  memoria_de_programa u_memoria (
    .addr_i (pc_q[ADDR_W-1:0]),
    .dado_c (prog_word_c)
  );

  // Fetch is blocked on a full edge even when a dispatch frees a slot; refill follows next edge.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    pc_d    = pc_q;
    out_d   = out_q;
    fetch_c = (count_q < CNT_W'(DEPTH)) && (pc_q < PC_W'(PROG_LEN));
    pop_c   = Pop && (count_q != '0);

    if (fetch_c) begin
      tail_d = (tail_q == PTR_W'(DEPTH - 1)) ? '0 : tail_q + PTR_W'(1);
      pc_d   = pc_q + PC_W'(1);
    end

    if (pop_c) begin
      head_d = (head_q == PTR_W'(DEPTH - 1)) ? '0 : head_q + PTR_W'(1);
      out_d  = mem_q[head_q];
    end

    case ({fetch_c, pop_c})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      pc_q    <= '0;
      out_q   <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      pc_q    <= pc_d;
      out_q   <= out_d;
    end
  end

  // Queue storage carries no reset; occupancy tracking alone defines valid entries.
  always_ff @(posedge Clock) begin
    if (fetch_c) begin
      mem_q[tail_q] <= WIDTH'(prog_word_c);
    end
  end

  assign Instrucao_Despachada = out_q;
  assign Full                 = (count_q == CNT_W'(DEPTH));
  assign Empty                = (count_q == '0);

endmodule

// File: tb/tb_fila_de_instrucoes.sv
// Scoreboard bench for fila_de_instrucoes: stimulus pushes expected per-edge outputs,
// a monitor pops and compares them just after each rising edge.
module tb_fila_de_instrucoes;

  logic        Clock;
  logic        Reset;
  logic        Pop;
  logic [15:0] Instrucao_Despachada;
  logic        Full;
  logic        Empty;

  typedef struct {
    logic [15:0] instr;
    logic        full;
    logic        empty;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  int          m_count = 0;
  int          m_pc    = 0;
  int          m_next  = 0;
  logic [15:0] m_out   = 16'h0000;

  fila_de_instrucoes dut (
    .Clock                (Clock),
    .Reset                (Reset),
    .Pop                  (Pop),
    .Instrucao_Despachada (Instrucao_Despachada),
    .Full                 (Full),
    .Empty                (Empty)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_count = 0;
    m_pc    = 0;
    m_next  = 0;
    m_out   = 16'h0000;
  endtask

  // Reference behaviour for one rising edge, computed from pre-edge model state.
  task automatic drive(input logic p);
    bit   pop_ok;
    bit   fet;
    exp_t e;
    Pop    = p;
    pop_ok = p && (m_count != 0);
    fet    = (m_count < 8) && (m_pc < 16);
    if (pop_ok) begin
      m_out = 16'hA000 | 16'(m_next);
      m_next++;
    end
    m_count = m_count + int'(fet) - int'(pop_ok);
    if (fet) m_pc++;
    e.instr = m_out;
    e.full  = (m_count == 8);
    e.empty = (m_count == 0);
    exp_q.push_back(e);
  endtask

  task automatic step(input logic p);
    @(negedge Clock);
    drive(p);
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_instr"}, Instrucao_Despachada, 16'h0000);
    chk({tag, "_full"},  16'(Full),  16'h0000);
    chk({tag, "_empty"}, 16'(Empty), 16'h0001);
  endtask

  // Monitor: compare the expectation queued for each edge just after that edge.
  always begin
    exp_t e;
    @(posedge Clock);
    #1;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      chk("mon_instr", Instrucao_Despachada, e.instr);
      chk("mon_full",  16'(Full),  16'(e.full));
      chk("mon_empty", 16'(Empty), 16'(e.empty));
    end
  end

  initial begin
    Reset = 1'b0;
    Pop   = 1'b0;
    repeat (2) @(negedge Clock);
    check_reset_values("rst_pop0");
    Pop = 1'b1;
    @(posedge Clock); #2;
    check_reset_values("rst_pop1");

    // Release with Pop held: first edge fetches but cannot dispatch.
    @(negedge Clock);
    Reset = 1'b1;
    drive(1'b1);
    for (int i = 0; i < 7; i++) step(1'b0);
    @(posedge Clock); #2;
    chk("full_after_8", 16'(Full), 16'h0001);
    for (int i = 0; i < 3; i++) step(1'b0);

    // Single pulse from full: no refill on that edge, refill on the next.
    step(1'b1);
    @(posedge Clock); #2;
    chk("pulse_out", Instrucao_Despachada, 16'hA000);
    chk("pulse_full", 16'(Full), 16'h0000);
    step(1'b0);
    step(1'b0);

    // Drain the remainder and keep popping while empty.
    for (int i = 0; i < 20; i++) step(1'b1);
    @(posedge Clock); #2;
    chk("drain_hold", Instrucao_Despachada, 16'hA00F);
    chk("drain_empty", 16'(Empty), 16'h0001);

    // Refill after reset, partially drain, then assert reset between edges.
    @(negedge Clock);
    Reset = 1'b0;
    Pop   = 1'b0;
    model_reset();
    #1;
    check_reset_values("rst2");
    @(negedge Clock);
    Reset = 1'b1;
    drive(1'b0);
    for (int i = 0; i < 8; i++) step(1'b0);
    for (int i = 0; i < 3; i++) step(1'b1);
    @(posedge Clock); #2;
    chk("part_drain", Instrucao_Despachada, 16'hA002);
    #2;
    Reset = 1'b0;
    #1;
    check_reset_values("async_rst");
    model_reset();
    @(negedge Clock);
    Reset = 1'b1;
    drive(1'b0);
    for (int i = 0; i < 8; i++) step(1'b0);
    for (int i = 0; i < 18; i++) step(1'b1);
    step(1'b0);

    repeat (2) @(negedge Clock);
    if (exp_q.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
